// File: rtl/digit_serial_addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM state
// encodings and elaboration-time helpers for parameter checking and sizing.
package digit_serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Legal when the operand splits into a whole number of non-empty digits.
  function automatic bit legal_cfg(input int unsigned width, input int unsigned digit);
    return (digit != 0) && (width % digit == 0);
  endfunction

  // Digit counter width: enough to count NDIG digits, never narrower than 1.
  function automatic int unsigned cnt_width(input int unsigned ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/digit_serial_addsub_if.sv
// Request/response bundle for digit_serial_addsub.
//   master: drives start, sub, a, b; observes busy, done, result, flags.
//   slave : the arithmetic unit side.
interface digit_serial_addsub_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, overflow, zero
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, overflow, zero
  );
endinterface

// File: rtl/digit_serial_addsub_digit.sv
// addsub_digit: combinational DIGIT-bit adder with carry-in.
//   a, b   : digit operands
//   cin    : carry into the digit
//   sum_c  : digit sum
//   cout_c : carry out of the digit MSB
module addsub_digit #(
  parameter int unsigned DIGIT = 8
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum_c,
  output logic             cout_c
);
  localparam int unsigned SW = DIGIT + 1;

  assign {cout_c, sum_c} = {1'b0, a} + {1'b0, b} + SW'(cin);
endmodule

// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub: multicycle WIDTH-bit adder/subtractor processing
// DIGIT bits per clock with a registered ripple carry between digits.
//   clk, rst_n : clock, synchronous active-low reset
//   bus.start/sub/a/b : request, accepted when not busy
//   bus.busy   : high while digits are being processed
//   bus.done   : one-cycle pulse when result and flags are valid
//   bus.result : sum/difference, held until the next accepted start
//   bus.cout/overflow/zero : carry (no-borrow on sub), signed overflow, zero
module digit_serial_addsub
  import digit_serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 8
) (
  input logic                clk,
  input logic                rst_n,
  digit_serial_addsub_if.slave bus
);
  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = cnt_width(NDIG);

  if (!legal_cfg(WIDTH, DIGIT)) begin : g_bad_cfg
    $error("digit_serial_addsub: WIDTH must be a nonzero multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [DIGIT-1:0] dig_sum_c;
  logic             dig_cout_c;
  logic             last_digit_c;

  // Operands shift right each cycle, so the active digit is always at the bottom.
  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a      (opa_q[DIGIT-1:0]),
    .b      (opb_q[DIGIT-1:0]),
    .cin    (carry_q),
    .sum_c  (dig_sum_c),
    .cout_c (dig_cout_c)
  );

  assign last_digit_c = (cnt_q == CW'(NDIG - 1));

  // Next-state, datapath and flag logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    carry_d  = carry_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    done_d   = 1'b0;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          // Subtract as A + ~B + 1: invert B here, inject the +1 as carry-in.
          state_d = RUN;
          opa_d   = bus.a;
          opb_d   = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub;
          cnt_d   = '0;
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = opb_d[WIDTH-1];
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        opa_d   = opa_q >> DIGIT;
        opb_d   = opb_q >> DIGIT;
        carry_d = dig_cout_c;
        cnt_d   = cnt_q + CW'(1);
        // New digits enter at the top; after NDIG cycles digit k sits at slot k.
        result_d = (result_q >> DIGIT) | (WIDTH'(dig_sum_c) << (WIDTH - DIGIT));
        if (last_digit_c) begin
          state_d = DONE;
          done_d  = 1'b1;
          cout_d  = dig_cout_c;
          ovf_d   = (a_msb_q == b_msb_q) && (dig_sum_c[DIGIT-1] != a_msb_q);
          zero_d  = (result_d == '0);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;

endmodule

// File: doc/digit_serial_addsub.md
Name: digit_serial_addsub

Overview:
Parametrised multicycle adder/subtractor that adds or subtracts two WIDTH-bit operands DIGIT bits per clock, ripple-carrying between digits through a carry register. It supersedes the purely combinational 32-bit ripple adder wherever the multicycle datapath can trade latency for area, such as address and offset arithmetic in spare cycles. It adds a start/done handshake, a subtract mode and status flags: carry, signed overflow and zero.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of DIGIT.
DIGIT, 8, bits processed per cycle; 1 gives bit-serial operation, DIGIT=WIDTH gives single-cycle operation.
NDIG, WIDTH/DIGIT, derived local constant (number of digits); not overridable.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous reset, active-low
start  in  1  request; sampled only when not busy
sub  in  1  0 = A+B, 1 = A-B; sampled with start
a  in  WIDTH  operand A; sampled with start
b  in  WIDTH  operand B; sampled with start
busy  out  1  high while in RUN
done  out  1  one-cycle pulse when result valid
result  out  WIDTH  sum/difference; held until next accepted start
cout  out  1  carry out of MSB (sub: 1 = no borrow)
overflow  out  1  two's-complement overflow
zero  out  1  result == 0

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset state: while rst_n=0 at an edge, the FSM goes to IDLE and busy, done, result, cout, overflow and zero all clear to 0. Reset mid-RUN abandons the operation and no done is produced.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE after NDIG RUN cycles.
  - DONE -> RUN if start is high, else DONE -> IDLE.
- Start acceptance: start is accepted in IDLE or DONE.
  - On acceptance, latch opA = a and opB = sub ? ~b : b.
  - Set carry register = sub and digit counter = 0.
  - Record operand sign bits a[WIDTH-1] and opB[WIDTH-1] for overflow.
- Start ignored while busy: a start that arrives during RUN is ignored, not queued, and operands are not disturbed.
- RUN cycle k (k = 0..NDIG-1):
  - Compute {c, s} = opA digit k + opB digit k + carry.
  - Write s into result digit k; carry <= c; counter increments.
  - Implementation may shift operands right instead of indexing; the result is identical.
- Final digit edge (k = NDIG-1):
  - cout <= c.
  - overflow <= (a_msb == opB_msb) && (s_msb != a_msb).
  - zero <= (complete result == 0).
  - State -> DONE.
- Latency: done is high exactly NDIG cycles after the edge that accepted start, for one cycle only.
- Output timing:
  - busy = (state == RUN).
  - result digits update during RUN and are not valid until done.
  - Flags are stale during RUN and valid from done onward.
- Back-to-back: start during the DONE cycle begins a new operation on the next edge, with no idle bubble.
- Arithmetic: modulo 2^WIDTH; no saturation. Subtraction is A + ~B + 1, so cout=1 means A >= B unsigned.
- Counter width: $clog2(NDIG) bits, minimum 1.
- DIGIT = WIDTH: single RUN cycle, so done follows start by 1 cycle.

Decomposition:
- Shared package/include holds the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and a parameter-legality check: WIDTH % DIGIT == 0, otherwise elaboration error.
- One sub-module, addsub_digit: a combinational DIGIT-bit adder with carry-in, exposing sum and carry-out.
- The top level holds the FSM, counter, operand and carry registers and flag logic.

Test Plan:
- WIDTH=32, DIGIT=8, add 0xFFFFFFFF + 0x00000001 -> result 0x00000000, cout=1, zero=1, overflow=0; done exactly 4 cycles after start, busy high for 4 cycles.
- Add 0x7FFFFFFF + 0x00000001 -> 0x80000000, overflow=1, cout=0, zero=0.
- Sub 5 - 7 -> 0xFFFFFFFE, cout=0, overflow=0. Then, in the DONE cycle, start sub 0x80000000 - 1 -> 0x7FFFFFFF, overflow=1, cout=1; no bubble between operations.
- Pulse start again 2 cycles into a running add of 0x12345678 + 0x11111111 with different operands -> new start ignored, result 0x23456789, single done pulse.
- Assert rst_n=0 for one cycle mid-RUN -> next cycle all outputs 0, state IDLE, no done. A subsequent add of 3 + 4 -> 7.
- Re-run the vectors above with DIGIT=1 (done after 32 cycles) and DIGIT=32 (done after 1 cycle) -> identical results and flags.
